// File: rtl/jtcontra_obj_rom_pkg.sv
// jtcontra_obj_rom_pkg: FSM encoding, default SDRAM offset and cache entry type for the object ROM slot
package jtcontra_obj_rom_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, PREF = 2'd3} state_t;
    localparam logic [21:0] DEF_OFFSET = 22'h0;
    localparam int CACHE_AW = 18;
    localparam int CACHE_DW = 16;
    typedef struct packed {
        logic [CACHE_AW-1:0] tag;
        logic [CACHE_DW-1:0] data;
        logic                valid;
    } entry_t;
endpackage

// File: rtl/jtcontra_obj_rom_slot.sv
// jtcontra_obj_rom_slot: cached ROM responder turning object-engine fetches into SDRAM bursts
// JTCONTRA_OBJ_PREFETCH_EN adds a second entry filled by an automatic fetch of the other half-row (addr^1)
module jtcontra_obj_rom_slot
    import jtcontra_obj_rom_pkg::*;
#(
    parameter int              AW     = CACHE_AW,
    parameter int              SW     = 22,
    parameter logic [SW-1:0]   OFFSET = SW'(DEF_OFFSET),
    parameter int              DW     = CACHE_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_cs,
    input  logic [AW-1:0] rom_addr,
    output logic          rom_ok,
    output logic [DW-1:0] rom_data,
    output logic          sdram_req,
    output logic [SW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [DW-1:0] sdram_din
);
`ifdef JTCONTRA_OBJ_PREFETCH_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif
    entry_t        cache [NE];
    state_t        state, state_nx;
    logic [AW-1:0] req_addr;
    logic          hit;
    logic [DW-1:0] hit_data;
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < NE; i++)
            if (rom_cs && cache[i].valid && cache[i].tag == CACHE_AW'(rom_addr)) begin
                hit      = 1'b1;
                hit_data = DW'(cache[i].data);
            end
    end
`ifdef JTCONTRA_OBJ_PREFETCH_EN
    logic [AW-1:0] alt_addr;
    logic          alt_hit, alt_ent, dem_ent, pf, ent;
    assign alt_addr = req_addr ^ AW'(1);
    // the demand fill must not evict the entry already holding the other half-row
    assign dem_ent  = alt_hit ? !alt_ent : 1'b0;
    always_comb begin
        alt_hit = 1'b0;
        alt_ent = 1'b0;
        for (int i = 0; i < NE; i++)
            if (cache[i].valid && cache[i].tag == CACHE_AW'(alt_addr)) begin
                alt_hit = 1'b1;
                alt_ent = 1'(i);
            end
    end
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = (rom_cs && !hit) ? REQ : IDLE;
            REQ:  state_nx = sdram_ack ? WAIT : REQ;
`ifdef JTCONTRA_OBJ_PREFETCH_EN
            WAIT: state_nx = !data_rdy ? WAIT : (!pf && !alt_hit) ? PREF : IDLE;
            PREF: state_nx = sdram_ack ? WAIT : PREF;
`else
            WAIT: state_nx = data_rdy ? IDLE : WAIT;
            PREF: state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_ok     <= 1'b0;
            rom_data   <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= OFFSET;
            req_addr   <= '0;
            for (int i = 0; i < NE; i++) cache[i] <= '0;
`ifdef JTCONTRA_OBJ_PREFETCH_EN
            pf  <= 1'b0;
            ent <= 1'b0;
`endif
        end else begin
            rom_ok <= hit;
            if (hit) rom_data <= hit_data;
            if (state == IDLE && state_nx == REQ) begin
                req_addr   <= rom_addr;
                sdram_req  <= 1'b1;
                sdram_addr <= OFFSET + SW'(rom_addr);
            end
            if ((state == REQ || state == PREF) && sdram_ack) sdram_req <= 1'b0;
`ifdef JTCONTRA_OBJ_PREFETCH_EN
            if (state == WAIT && data_rdy) begin
                cache[pf ? ent : dem_ent] <= '{tag: CACHE_AW'(req_addr), data: CACHE_DW'(sdram_din), valid: 1'b1};
                pf <= state_nx == PREF;
            end
            if (state == WAIT && state_nx == PREF) begin
                req_addr   <= alt_addr;
                ent        <= !dem_ent;
                sdram_req  <= 1'b1;
                sdram_addr <= OFFSET + SW'(alt_addr);
            end
`else
            if (state == WAIT && data_rdy)
                cache[0] <= '{tag: CACHE_AW'(req_addr), data: CACHE_DW'(sdram_din), valid: 1'b1};
`endif
        end
    end
endmodule

// File: tb/tb_jtcontra_obj_rom_slot.sv
// tb_jtcontra_obj_rom_slot: directed checks of miss/hit timing, mid-fetch cancel, reset and prefetch
module tb_jtcontra_obj_rom_slot;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_cs = 1'b0;
    logic [17:0] rom_addr = '0;
    logic        rom_ok;
    logic [15:0] rom_data;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        data_rdy = 1'b0;
    logic [15:0] sdram_din = '0;
    int          checks = 0;
    int          failures = 0;

    jtcontra_obj_rom_slot #(.OFFSET(22'h10000)) dut (
        .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_ok(rom_ok), .rom_data(rom_data), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
        .sdram_din(sdram_din)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ack_pulse();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic fill(input logic [15:0] d);
        data_rdy  = 1'b1;
        sdram_din = d;
        tick();
        data_rdy  = 1'b0;
        sdram_din = '0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ok", rom_ok, 0);
        chk("rst_data", rom_data, 0);
        chk("rst_req", sdram_req, 0);
        chk("rst_addr", sdram_addr, 22'h10000);
        rst = 1'b0;
        tick();
`ifdef JTCONTRA_OBJ_PREFETCH_EN
        rom_cs = 1'b1; rom_addr = 18'h0100;
        tick();
        chk("pf_dem_req", sdram_req, 1);
        chk("pf_dem_addr", sdram_addr, 22'h10100);
        ack_pulse();
        chk("pf_dem_ack", sdram_req, 0);
        fill(16'hAAAA);
        chk("pf_req", sdram_req, 1);
        chk("pf_addr", sdram_addr, 22'h10101);
        ack_pulse();
        chk("pf_dem_ok", rom_ok, 1);
        chk("pf_dem_data", rom_data, 16'hAAAA);
        chk("pf_ack", sdram_req, 0);
        fill(16'hBBBB);
        chk("pf_idle_req", sdram_req, 0);
        rom_addr = 18'h0101;
        tick();
        chk("pf_hit_ok", rom_ok, 1);
        chk("pf_hit_data", rom_data, 16'hBBBB);
        chk("pf_hit_req", sdram_req, 0);
        rom_addr = 18'h0100;
        tick();
        chk("pf_keep_ok", rom_ok, 1);
        chk("pf_keep_data", rom_data, 16'hAAAA);
`else
        rom_cs = 1'b1; rom_addr = 18'h00A4;
        tick();
        chk("cold_req", sdram_req, 1);
        chk("cold_addr", sdram_addr, 22'h100A4);
        chk("cold_ok", rom_ok, 0);
        repeat (2) tick();
        chk("cold_hold", sdram_req, 1);
        ack_pulse();
        chk("cold_ack", sdram_req, 0);
        repeat (3) tick();
        fill(16'hBEEF);
        chk("fill_ok0", rom_ok, 0);
        chk("fill_noreq", sdram_req, 0);
        tick();
        chk("fill_ok1", rom_ok, 1);
        chk("fill_data", rom_data, 16'hBEEF);
        chk("fill_req", sdram_req, 0);
        rom_cs = 1'b0;
        tick();
        chk("drop_ok", rom_ok, 0);
        rom_cs = 1'b1;
        tick();
        chk("rehit_ok", rom_ok, 1);
        chk("rehit_data", rom_data, 16'hBEEF);
        chk("rehit_req", sdram_req, 0);
        rom_addr = 18'h00A5;
        tick();
        chk("sw_ok", rom_ok, 0);
        chk("sw_req", sdram_req, 1);
        chk("sw_addr", sdram_addr, 22'h100A5);
        ack_pulse();
        rom_cs = 1'b0;
        tick();
        fill(16'h1234);
        repeat (2) tick();
        chk("cancel_ok", rom_ok, 0);
        chk("cancel_req", sdram_req, 0);
        rom_cs = 1'b1;
        tick();
        chk("cancel_hit", rom_ok, 1);
        chk("cancel_data", rom_data, 16'h1234);
        chk("cancel_noreq", sdram_req, 0);
        rom_addr = 18'h00A4;
        tick();
        chk("evict_ok", rom_ok, 0);
        chk("evict_req", sdram_req, 1);
        chk("evict_addr", sdram_addr, 22'h100A4);
        ack_pulse();
        rom_cs = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ok", rom_ok, 0);
        chk("mrst_data", rom_data, 0);
        chk("mrst_req", sdram_req, 0);
        chk("mrst_addr", sdram_addr, 22'h10000);
        sdram_ack = 1'b1;
        fill(16'hDEAD);
        sdram_ack = 1'b0;
        chk("stray_req", sdram_req, 0);
        tick();
        rom_cs = 1'b1; rom_addr = 18'h00A5;
        tick();
        chk("post_ok", rom_ok, 0);
        chk("post_req", sdram_req, 1);
        chk("post_addr", sdram_addr, 22'h100A5);
        ack_pulse();
        fill(16'h5555);
        tick();
        chk("post_hit", rom_ok, 1);
        chk("post_data", rom_data, 16'h5555);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtcontra_obj_rom_slot.md
Name: jtcontra_obj_rom_slot

Overview:
- Responder for the object engine's ROM request handshake (rom_cs / rom_addr / rom_ok / rom_data).
- Turns each client request into an SDRAM burst request through a request/ack/data-ready port.
- Keeps a small tagged cache, so repeated or adjacent half-row fetches return without an SDRAM trip.
- Sits between the object renderer and the SDRAM controller. One instance is used per 007121 object layer.

Parameters:
- AW, 18: client word-address width.
- SW, 22: SDRAM word-address width.
- OFFSET, 22'h0: base added to the zero-extended rom_addr to form sdram_addr.
- DW, 16: data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; one clock domain only.
- rom_cs  in  1  client request strobe.
- rom_addr  in  AW  client word address.
- rom_ok  out  1  data valid for the current rom_addr.
- rom_data  out  DW  read data.
- sdram_req  out  1  request to the SDRAM controller.
- sdram_addr  out  SW  request address, equal to OFFSET + rom_addr.
- sdram_ack  in  1  request accepted, one-cycle pulse.
- data_rdy  in  1  sdram_din valid, one-cycle pulse.
- sdram_din  in  DW  SDRAM read data.

Behaviour:
- Reset values: rom_ok=0, rom_data=0, sdram_req=0, sdram_addr=OFFSET, all cache valid bits cleared, FSM=IDLE.
- Cache: entry0 holds tag[AW-1:0], data and valid.
- Hit is combinational: rom_cs and a valid entry whose tag equals rom_addr.
- rom_ok is registered: rom_ok <= hit, and rom_data <= data of the hit entry.
  - So a hit is visible one clock after rom_cs/rom_addr become stable.
  - If rom_addr changes on the same edge rom_cs rises, rom_ok stays 0 in the next cycle unless the new address hits.
  - This guarantees the client's one-cycle settle wait never sees a stale rom_ok.
- rom_ok drops in the cycle after rom_cs falls or rom_addr changes to a missing address.
- FSM states:
  - IDLE: if rom_cs and no hit, latch req_addr=rom_addr, drive sdram_addr=OFFSET+req_addr, set sdram_req=1, go to REQ.
  - REQ: hold sdram_req until sdram_ack=1; then sdram_req=0, go to WAIT.
  - WAIT: on data_rdy, write {req_addr, sdram_din, valid=1} into entry0 and go to IDLE.
- Hit latency: the cache is written on the data_rdy edge. The hit is evaluated in the next cycle, and rom_ok rises the cycle after that.
- Miss latency: 2 cycles plus SDRAM latency.
- If rom_cs falls or rom_addr changes mid-fetch, the fetch still completes and fills the cache. No abort is issued to the SDRAM. After returning to IDLE, the current rom_addr is re-evaluated.
- data_rdy or sdram_ack arriving outside REQ/WAIT, including after a reset mid-fetch, is ignored.
- Addresses wrap modulo 2^SW after OFFSET addition; no overflow flag.
- Back-to-back requests: a new miss is issued from IDLE on the cycle after the fill, never in the same cycle.

Optional Feature:
- Macro: JTCONTRA_OBJ_PREFETCH_EN.
- Enabled:
  - A second entry (entry1) is added.
  - After a demand fill of address A, the FSM automatically issues a fetch of A^1 (the other h4 half of the row) and fills entry1, unless A^1 already hits.
  - If a new demand miss arrives while the prefetch is in REQ, the demand is queued. It is served immediately after the prefetch fill.
  - Fills alternate entries: the demand goes to the entry not holding A^1, the prefetch to the other.
- Disabled: single entry; no prefetch logic is present.

Decomposition:
- Package jtcontra_obj_rom_pkg holds:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, PREF=2'd3);
  - the default OFFSET;
  - a cache-entry struct {tag, data, valid}.
- No sub-module is natural: tag compare and FSM stay in one module. The cache entry is an array inside it.

Test Plan:
- Cold miss, rom_cs=1, rom_addr=18'h00A4, OFFSET=22'h10000: sdram_req rises next cycle with sdram_addr=22'h100A4. The SDRAM acks after 3 cycles and sends data_rdy with 16'hBEEF 4 cycles later. rom_ok=1 with rom_data=16'hBEEF two cycles after data_rdy.
- Repeat hit: rom_cs drops, then re-asserts with 18'h00A4 → rom_ok=1 one cycle later, sdram_req stays 0.
- Address switch: rom_cs held and rom_addr changed to 18'h00A5 on one edge → rom_ok=0 in the following cycle, and a new request goes out for 22'h100A5.
- Mid-fetch cancel: rom_cs dropped during WAIT → the fill still completes, rom_ok stays 0. A later request to the same address hits with no SDRAM request.
- Reset in WAIT: rst pulsed, then data_rdy arrives → cache stays invalid, rom_ok=0, FSM=IDLE.
- Prefetch (macro on): a miss on 18'h0100 → a second sdram_req for 18'h0101 follows automatically. A client request to 18'h0101 afterwards hits in one cycle.
